// File: rtl/multi_chan_fifo_pkg.sv
// Shared sizing helpers for the multi-channel FIFO.
// Channel index width, pointer width and almost-full threshold.
package multi_chan_fifo_pkg;

   function automatic int chan_w(input int nch);
      return (nch <= 1) ? 1 : $clog2(nch);
   endfunction

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int af_level(input int depth, input int margin);
      return depth - margin;
   endfunction

endpackage

// File: rtl/fifo_chan.sv
// One ring-buffer channel: storage, read/write pointers and occupancy.
// enq/deq arrive already qualified by the channel's own ready state.
module fifo_chan
   import multi_chan_fifo_pkg::*;
#(
   parameter int WIDTH     = 3,
   parameter int DEPTH     = 4,
   parameter int AF_MARGIN = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enq,
   input  logic                    deq,
   input  logic                    clear,
   input  logic [WIDTH-1:0]        enq_data,
   output logic [WIDTH-1:0]        head,
   output logic                    full,
   output logic                    empty,
   output logic                    safe,
   output logic [addr_w(DEPTH):0]  count
);

   localparam int AW = addr_w(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_LVL   = (AW+1)'(af_level(DEPTH, AF_MARGIN));

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [AW:0]      cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + 1'b1;
         if (deq) rd_ptr <= rd_ptr + 1'b1;
         case ({enq, deq})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is deliberately left out of reset; head masks stale data.
   always_ff @(posedge clk) begin
      if (enq && !clear) mem[wr_ptr] <= enq_data;
   end

   assign empty = (cnt == '0);
   assign full  = (cnt == FULL_LVL);
   assign safe  = (cnt < AF_LVL);
   assign head  = empty ? '0 : mem[rd_ptr];
   assign count = cnt;

endmodule

// File: rtl/multi_chan_fifo.sv
// NCH independent FIFO channels behind one enqueue and one dequeue port.
// Channel indices are decoded to one-hot fires; out-of-range indices are never ready.
module multi_chan_fifo
   import multi_chan_fifo_pkg::*;
#(
   parameter int WIDTH     = 3,
   parameter int DEPTH     = 4,
   parameter int NCH       = 2,
   parameter int AF_MARGIN = 1
) (
   input  logic                              CLK,
   input  logic                              RST_N,
   input  logic                              EN_enq,
   input  logic [chan_w(NCH)-1:0]            enq_chan,
   input  logic [WIDTH-1:0]                  enq_data,
   output logic                              RDY_enq,
   input  logic                              EN_deq,
   input  logic [chan_w(NCH)-1:0]            deq_chan,
   output logic                              RDY_deq,
   input  logic                              EN_clear,
   output logic [NCH*WIDTH-1:0]              first,
   output logic [NCH-1:0]                    not_empty,
   output logic [NCH-1:0]                    safe_to_enq,
   output logic [NCH*(addr_w(DEPTH)+1)-1:0]  count
);

   localparam int CW = chan_w(NCH);
   localparam int AW = addr_w(DEPTH);

   logic [NCH-1:0] full;
   logic [NCH-1:0] empty;
   logic [NCH-1:0] enq_sel;
   logic [NCH-1:0] deq_sel;

   always_comb begin
      RDY_enq = 1'b0;
      RDY_deq = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         if (enq_chan == CW'(c)) RDY_enq = !full[c];
         if (deq_chan == CW'(c)) RDY_deq = !empty[c];
      end
   end

   always_comb begin
      enq_sel = '0;
      deq_sel = '0;
      for (int c = 0; c < NCH; c++) begin
         enq_sel[c] = EN_enq && RDY_enq && (enq_chan == CW'(c));
         deq_sel[c] = EN_deq && RDY_deq && (deq_chan == CW'(c));
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      fifo_chan #(
         .WIDTH     (WIDTH),
         .DEPTH     (DEPTH),
         .AF_MARGIN (AF_MARGIN)
      ) u_chan (
         .clk      (CLK),
         .rst_n    (RST_N),
         .enq      (enq_sel[c]),
         .deq      (deq_sel[c]),
         .clear    (EN_clear),
         .enq_data (enq_data),
         .head     (first[c*WIDTH +: WIDTH]),
         .full     (full[c]),
         .empty    (empty[c]),
         .safe     (safe_to_enq[c]),
         .count    (count[c*(AW+1) +: AW+1])
      );
   end

   assign not_empty = ~empty;

endmodule

// File: tb/tb_multi_chan_fifo.sv
// Bench for multi_chan_fifo: queue model checked every cycle plus directed literals.
// A second NCH=3 instance covers out-of-range channel and clear priority.
module tb_multi_chan_fifo;

   localparam int WIDTH = 3;
   localparam int DEPTH = 4;
   localparam int NCH   = 2;
   localparam int AFM   = 1;
   localparam int CNTW  = 3;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       RST_N = 1'b0;
   logic       EN_enq = 1'b0;
   logic [0:0] enq_chan = '0;
   logic [2:0] enq_data = '0;
   logic       RDY_enq;
   logic       EN_deq = 1'b0;
   logic [0:0] deq_chan = '0;
   logic       RDY_deq;
   logic       EN_clear = 1'b0;
   logic [5:0] first;
   logic [1:0] not_empty;
   logic [1:0] safe_to_enq;
   logic [5:0] count;

   logic       e3_enq = 1'b0;
   logic [1:0] c3_enq = '0;
   logic [2:0] d3_enq = '0;
   logic       r3_enq;
   logic       e3_deq = 1'b0;
   logic [1:0] c3_deq = '0;
   logic       r3_deq;
   logic       e3_clr = 1'b0;
   logic [8:0] f3;
   logic [2:0] ne3;
   logic [2:0] s3;
   logic [8:0] cnt3;

   multi_chan_fifo #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .NCH(NCH), .AF_MARGIN(AFM)
   ) dut (
      .CLK(CLK), .RST_N(RST_N),
      .EN_enq(EN_enq), .enq_chan(enq_chan), .enq_data(enq_data),
      .RDY_enq(RDY_enq),
      .EN_deq(EN_deq), .deq_chan(deq_chan), .RDY_deq(RDY_deq),
      .EN_clear(EN_clear),
      .first(first), .not_empty(not_empty),
      .safe_to_enq(safe_to_enq), .count(count)
   );

   multi_chan_fifo #(
      .WIDTH(3), .DEPTH(4), .NCH(3), .AF_MARGIN(1)
   ) dut3 (
      .CLK(CLK), .RST_N(RST_N),
      .EN_enq(e3_enq), .enq_chan(c3_enq), .enq_data(d3_enq),
      .RDY_enq(r3_enq),
      .EN_deq(e3_deq), .deq_chan(c3_deq), .RDY_deq(r3_deq),
      .EN_clear(e3_clr),
      .first(f3), .not_empty(ne3),
      .safe_to_enq(s3), .count(cnt3)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural model: one queue per channel.
   logic [2:0] mq [NCH][$];
   bit fe, fd;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int c = 0; c < NCH; c++) mq[c].delete();
      end else if (EN_clear) begin
         for (int c = 0; c < NCH; c++) mq[c].delete();
      end else begin
         fe = EN_enq && mq[enq_chan].size() < DEPTH;
         fd = EN_deq && mq[deq_chan].size() > 0;
         if (fd) void'(mq[deq_chan].pop_front());
         if (fe) mq[enq_chan].push_back(enq_data);
      end
   end

   logic [5:0] x_first, x_count;
   logic [1:0] x_ne, x_safe;

   always @(negedge CLK) begin
      for (int c = 0; c < NCH; c++) begin
         x_first[c*WIDTH +: WIDTH] = (mq[c].size() > 0) ? mq[c][0] : 3'd0;
         x_count[c*CNTW +: CNTW]   = 3'(mq[c].size());
         x_ne[c]   = mq[c].size() > 0;
         x_safe[c] = mq[c].size() < DEPTH - AFM;
      end
      chk("first", 32'(first), 32'(x_first));
      chk("count", 32'(count), 32'(x_count));
      chk("not_empty", 32'(not_empty), 32'(x_ne));
      chk("safe_to_enq", 32'(safe_to_enq), 32'(x_safe));
      chk("rdy_enq", 32'(RDY_enq), 32'(mq[enq_chan].size() < DEPTH));
      chk("rdy_deq", 32'(RDY_deq), 32'(mq[deq_chan].size() > 0));
   end

   function automatic logic [2:0] hd(input int c);
      return first[c*WIDTH +: WIDTH];
   endfunction

   function automatic logic [2:0] cn(input int c);
      return count[c*CNTW +: CNTW];
   endfunction

   task automatic cyc(input logic e, input int ec, input int ed,
                      input logic d, input int dc, input logic clr = 1'b0);
      EN_enq   = e;
      enq_chan = 1'(ec);
      enq_data = 3'(ed);
      EN_deq   = d;
      deq_chan = 1'(dc);
      EN_clear = clr;
      @(posedge CLK);
      #1;
      EN_enq   = 1'b0;
      EN_deq   = 1'b0;
      EN_clear = 1'b0;
   endtask

   task automatic enq(input int c, input int v);
      cyc(1'b1, c, v, 1'b0, 0);
   endtask

   task automatic deq(input int c);
      cyc(1'b0, 0, 0, 1'b1, c);
   endtask

   task automatic cyc3(input logic e, input int ec, input int ed,
                       input logic clr);
      e3_enq = e;
      c3_enq = 2'(ec);
      d3_enq = 3'(ed);
      e3_clr = clr;
      @(posedge CLK);
      #1;
      e3_enq = 1'b0;
      e3_clr = 1'b0;
   endtask

   initial begin
      #12 RST_N = 1'b1;
      @(posedge CLK);
      #1;

      // Reset asserted asynchronously in the middle of traffic.
      enq(0, 3);
      enq(1, 5);
      enq(0, 2);
      EN_enq = 1'b1;
      enq_chan = 1'b0;
      #2 RST_N = 1'b0;
      #1;
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_not_empty", 32'(not_empty), 32'h0);
      chk("rst_rdy_deq", 32'(RDY_deq), 32'h0);
      chk("rst_rdy_enq", 32'(RDY_enq), 32'h1);
      chk("rst_first", 32'(first), 32'h0);
      chk("rst_safe", 32'(safe_to_enq), 32'h3);
      chk("rst_cnt3", 32'(cnt3), 32'h0);
      @(negedge CLK);
      EN_enq = 1'b0;
      #1 RST_N = 1'b1;
      @(posedge CLK);
      #1;

      // Fill channel 0, overflow attempt, then drain.
      enq(0, 1);
      enq(0, 2);
      chk("safe_at2", 32'(safe_to_enq[0]), 32'h1);
      enq(0, 3);
      chk("safe_at3", 32'(safe_to_enq[0]), 32'h0);
      enq(0, 4);
      chk("full_cnt", 32'(cn(0)), 32'd4);
      chk("full_rdy", 32'(RDY_enq), 32'h0);
      enq(0, 7);
      chk("ovf_cnt", 32'(cn(0)), 32'd4);
      chk("ovf_head", 32'(hd(0)), 32'd1);
      for (int v = 1; v <= 4; v++) begin
         chk("drain_head", 32'(hd(0)), 32'(v));
         deq(0);
      end
      chk("drained_ne", 32'(not_empty[0]), 32'h0);
      chk("drained_first", 32'(hd(0)), 32'h0);

      // Pointer wrap on channel 1.
      for (int i = 0; i < 10; i++) begin
         enq(1, i % 8);
         chk("wrap_head", 32'(hd(1)), 32'(i % 8));
         deq(1);
      end
      chk("wrap_cnt", 32'(cn(1)), 32'd0);

      // Same-channel enqueue and dequeue at count 2, full and empty.
      enq(0, 1);
      enq(0, 2);
      cyc(1'b1, 0, 3, 1'b1, 0);
      chk("sim2_cnt", 32'(cn(0)), 32'd2);
      chk("sim2_head", 32'(hd(0)), 32'd2);
      enq(0, 4);
      enq(0, 5);
      chk("sim4_pre", 32'(cn(0)), 32'd4);
      cyc(1'b1, 0, 6, 1'b1, 0);
      chk("sim4_cnt", 32'(cn(0)), 32'd3);
      chk("sim4_head", 32'(hd(0)), 32'd3);
      deq(0);
      deq(0);
      deq(0);
      chk("sim0_pre", 32'(cn(0)), 32'd0);
      cyc(1'b1, 0, 7, 1'b1, 0);
      chk("sim0_cnt", 32'(cn(0)), 32'd1);
      chk("sim0_head", 32'(hd(0)), 32'd7);
      deq(0);

      // Independent channels in the same cycle.
      enq(1, 6);
      cyc(1'b1, 0, 5, 1'b1, 1);
      chk("ind_cnt0", 32'(cn(0)), 32'd1);
      chk("ind_cnt1", 32'(cn(1)), 32'd0);
      chk("ind_head0", 32'(hd(0)), 32'd5);
      enq(1, 2);
      cyc(1'b1, 1, 3, 1'b0, 0, 1'b1);
      chk("clr_count", 32'(count), 32'h0);

      // NCH=3: out-of-range index and clear priority.
      c3_enq = 2'd3;
      e3_enq = 1'b1;
      d3_enq = 3'd2;
      #1;
      chk("oor_rdy", 32'(r3_enq), 32'h0);
      cyc3(1'b1, 3, 2, 1'b0);
      chk("oor_cnt", 32'(cnt3), 32'h0);
      cyc3(1'b1, 2, 4, 1'b0);
      chk("c2_cnt", 32'(cnt3), 32'h040);
      chk("c2_head", 32'(f3[8:6]), 32'd4);
      chk("c2_ne", 32'(ne3), 32'h4);
      cyc3(1'b1, 0, 1, 1'b0);
      chk("c0_cnt", 32'(cnt3), 32'h041);
      cyc3(1'b1, 1, 5, 1'b1);
      chk("clr3_cnt", 32'(cnt3), 32'h0);
      chk("clr3_ne", 32'(ne3), 32'h0);
      chk("clr3_safe", 32'(s3), 32'h7);

      @(negedge CLK);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
